// File: rtl/seg_scan_pkg.sv
// Shared constants and the hex-to-segment decode function for seg_scan_driver.
// Segment order is {p,g,f,e,d,c,b,a}; every code is active-low.
package seg_scan_pkg;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [7:0] hex2seg(input logic [3:0] nibble, input logic dp);
        logic [7:0] code;
        case (nibble)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = SEG_A;
            4'hB:    code = SEG_B;
            4'hC:    code = SEG_C;
            4'hD:    code = SEG_D;
            4'hE:    code = SEG_E;
            default: code = SEG_F;
        endcase
        code[7] = ~dp;
        return code;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of seg_scan_driver: display request inputs and the
// multiplexed segment/anode outputs. The driver uses the slave modport.
interface seg_scan_driver_if #(
    parameter int DIGITS = 8
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   point;
    logic [DIGITS-1:0]   blank;
    logic                le;
    logic                hold;
    logic                lz_en;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                frame_done;

    modport master (
        output data, point, blank, le, hold, lz_en,
        input  seg, an, frame_done
    );

    modport slave (
        input  data, point, blank, le, hold, lz_en,
        output seg, an, frame_done
    );
endinterface

// File: rtl/seg_hex_decoder.sv
// Single shared hex-to-7-segment decoder; en=0 forces every segment off.
module seg_hex_decoder
    import seg_scan_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       en,
    output logic [7:0] seg
);
    assign seg = en ? hex2seg(nibble, dp) : SEG_OFF;
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode display driver with frame-synchronous snapshot.
// Define SEG_SCAN_DEADTIME_EN to blank the anodes for DEAD cycles at each slot start.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DIV    = 100000,
    parameter int DEAD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_driver_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 16) begin : g_chk_digits
        $error("seg_scan_driver: DIGITS must be within 1..16");
    end
    if (DIV < 2) begin : g_chk_div
        $error("seg_scan_driver: DIV must be at least 2");
    end
    if (DEAD >= DIV) begin : g_chk_dead
        $error("seg_scan_driver: DEAD must be less than DIV");
    end

    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic [DIGITS-1:0][3:0]   snap_data;
    logic [DIGITS-1:0]        snap_point;
    logic [DIGITS-1:0]        snap_blank;
    logic                     load_pending;
    logic [7:0]               seg_q;
    logic [DIGITS-1:0]        an_q;
    logic                     frame_done_q;

    logic                     tick;
    logic                     frame_end;
    logic                     load;
    logic [DIGITS-1:0][3:0]   cur_data;
    logic [DIGITS-1:0]        cur_point;
    logic [DIGITS-1:0]        cur_blank;
    logic                     zero_above;
    logic                     suppress;
    logic                     dec_en;
    logic [7:0]               dec_seg;
    logic [7:0]               seg_next;
    logic [DIGITS-1:0]        an_next;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign load      = load_pending || (frame_end && !bus.hold);

    // The very first slot after reset shows live inputs, which are being loaded on that same edge.
    assign cur_data  = load_pending ? bus.data  : snap_data;
    assign cur_point = load_pending ? bus.point : snap_point;
    assign cur_blank = load_pending ? bus.blank : snap_blank;

    always_comb begin
        zero_above = 1'b1;
        for (int j = 0; j < DIGITS; j++) begin
            if (IW'(j) >= idx && cur_data[j] != 4'h0) zero_above = 1'b0;
        end
    end

    assign suppress = bus.lz_en && (idx != '0) && zero_above;
    assign dec_en   = !bus.le && !cur_blank[idx];

    seg_hex_decoder u_dec (
        .nibble (cur_data[idx]),
        .dp     (cur_point[idx]),
        .en     (dec_en),
        .seg    (dec_seg)
    );

    // A suppressed leading zero keeps only its decimal point.
    assign seg_next = (suppress && dec_en) ? {~cur_point[idx], 7'h7F} : dec_seg;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        an_next      = '1;
        an_next[idx] = 1'b0;
`ifdef SEG_SCAN_DEADTIME_EN
        if (cnt < CW'(DEAD)) an_next = '1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            idx          <= '0;
            snap_data    <= '0;
            snap_point   <= '0;
            snap_blank   <= '0;
            load_pending <= 1'b1;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            if (load) begin
                snap_data    <= bus.data;
                snap_point   <= bus.point;
                snap_blank   <= bus.blank;
                load_pending <= 1'b0;
            end
            seg_q        <= seg_next;
            an_q         <= an_next;
            frame_done_q <= frame_end;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule
